vga_scanout: RTL and testbench
==============================

# vga_scanout

Parametrised VGA scanout engine: generates programmable raster timing and fetches pixels from a framebuffer with configurable image size, runtime origin and 1x/2x integer scaling. It also provides optional front/back buffer swapping synchronised to vertical blanking. It sits between the video memory read port and the board VGA DAC, running entirely in the pixel clock domain.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths
- IMG_W, 256, image width in pixels; power of two
- IMG_H, 256, image height in pixels
- MEM_LAT, 1, framebuffer read latency in cycles; range 1..3
- BORDER_RGB, 12'h000, RGB444 colour for active pixels outside the image

Ports:
- clk  in  1  pixel clock (25 MHz nominal); the only clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  scanout enable
- x0  in  10  image origin column
- y0  in  9  image origin line
- scale2  in  1  0 = 1x, 1 = 2x pixel and line doubling
- swap_req  in  1  request a front/back buffer swap
- swap_ack  out  1  one-cycle pulse when the swap takes effect
- front_sel  out  1  buffer currently displayed
- fb_raddr  out  AW  framebuffer read address; AW = clog2(IMG_W*IMG_H), plus 1 MSB with VGA_DBUF_EN
- fb_rdata  in  12  RGB444 read data, valid MEM_LAT cycles after fb_raddr
- frame_start  out  1  one-cycle pulse at hc=0, vc=0
- VGA_HS, VGA_VS  out  1  active-low sync pulses
- VGA_BLANK_N  out  1  high during the active region
- VGA_SYNC_N  out  1  constant 0
- VGA_R, VGA_G, VGA_B  out  8  colour channels

## Operation
- Counters: hc counts 0..H_TOTAL-1; vc increments when hc wraps and counts 0..V_TOTAL-1. H_TOTAL is the sum of the H parameters; V_TOTAL likewise.
- Active region: hc < H_ACTIVE and vc < V_ACTIVE.
- Sync: HS is low for H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC. VS follows the same rule on vc.
- Shadow registers: x0, y0 and scale2 are captured into shadow registers on the last cycle of each frame (hc=H_TOTAL-1, vc=V_TOTAL-1) and on the first cycle after en rises. Changes mid-frame never tear.
- Image window: with s = 1 or 2, a pixel is in the image when x0 ≤ hc < x0+IMG_W·s and y0 ≤ vc < y0+IMG_H·s.
  - Window parts beyond the active region are clipped.
  - Compare arithmetic is 11 bits wide, so x0+IMG_W·s never wraps.
- Address: fb_raddr = {front_sel?, (vc-y0)>>(s-1), (hc-x0)>>(s-1)}. The column field is clog2(IMG_W) bits. Outside the window the address holds its last value.
- Pixel select: image pixel, else BORDER_RGB if active, else 0. Each 4-bit channel is expanded to 8 bits by replication ({c,c}), not zero padding.
- en low: counters clear synchronously, HS/VS are driven high, BLANK_N and RGB are 0, and no addresses are issued. A pending swap is retained.

## Timing
- Reset values: HS=1, VS=1, BLANK_N=0, RGB=0, swap_ack=0, front_sel=0, frame_start=0, fb_raddr=0. Counters and the swap-pending flag clear.
- fb_raddr is registered 1 cycle after the counter state.
- All VGA outputs are registered and appear L = MEM_LAT+2 cycles after the counter state. HS, VS and BLANK_N are delayed by the same L, so colour and sync stay aligned.
- frame_start is undelayed (counter stage).
- Swap handshake:
  - A swap_req high in any cycle sets pending; multiple requests coalesce.
  - The swap point is hc=0, vc=V_ACTIVE. At that cycle, if pending or swap_req is set, front_sel toggles, swap_ack pulses for 1 cycle and pending clears.
  - A request during the swap cycle is consumed by that swap.
- Reset mid-frame: immediate restart at hc=vc=0, with all outputs at their reset values.

## Configuration
- VGA_DBUF_EN defined: double buffering. fb_raddr gains an MSB equal to front_sel, and the swap logic is present.
- VGA_DBUF_EN undefined: fb_raddr is AW bits, front_sel=0 and swap_ack=0 constantly, swap_req is ignored, and the pending flag is not synthesised.

## Structure
- Package vga_pkg holds:
  - the default timing constants
  - typedef rgb444_t (packed r/g/b nibbles)
  - function expand4to8
- Sub-module vga_timing_gen holds the hc/vc counters, the sync decode, frame_start and the en handling.
- vga_scanout holds the shadow registers, window/address logic, swap logic and the alignment pipeline.

## Test plan
- Reset release, en=1, defaults: first HS falling edge at cycle 656+L after en; line period 800; VS low for lines 490–491; frame period 420000 cycles.
- x0=100, y0=50, scale2=0, fb_rdata=addr[11:0]: pixel (100,50) shows address 0; (355,50) shows 255; (356,50) is BORDER_RGB; fb_rdata=12'hA5F outputs R=AA, G=55, B=FF.
- scale2=1, x0=0, y0=0: hc 0–1 both read column 0; lines 0–1 read row 0; 512 pixels per line in the window.
- x0=500, scale2=1: the window is clipped at hc=639 and BLANK_N is low from hc=640; no address is issued beyond the active region.
- VGA_DBUF_EN: swap_req pulsed twice mid-frame gives one toggle at hc=0, vc=480, with a 1-cycle swap_ack. swap_req asserted exactly at the swap point is taken that frame.
- en dropped mid-line then raised: outputs blank immediately, pending preserved, and timing restarts from hc=vc=0 using newly sampled x0/y0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types, default raster timing and colour helpers for the VGA scanout slice.
package vga_pkg;

   localparam int CNT_W = 11;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   typedef struct packed {
      logic hs;
      logic vs;
      logic active;
      logic inwin;
   } ctl_t;

   localparam ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0, inwin: 1'b0};

   function automatic logic [7:0] expand4to8(input logic [3:0] c);
      return {c, c};
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters, sync decode and frame markers; counters are held at zero while en is low.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] hc,
   output logic [CNT_W-1:0] vc,
   output logic             hs,
   output logic             vs,
   output logic             active,
   output logic             frame_start,
   output logic             frame_last
);

   localparam logic [CNT_W-1:0] HA    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] HS0   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS1   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] HLAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] VA    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] VS0   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS1   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] VLAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc <= '0;
         vc <= '0;
      end else if (!en) begin
         hc <= '0;
         vc <= '0;
      end else if (hc == HLAST) begin
         hc <= '0;
         vc <= (vc == VLAST) ? '0 : vc + CNT_W'(1);
      end else begin
         hc <= hc + CNT_W'(1);
      end
   end

   // rst_n gates frame_start so the idle zero count never looks like a frame origin.
   always_comb begin
      hs          = 1'b1;
      vs          = 1'b1;
      active      = 1'b0;
      frame_start = 1'b0;
      frame_last  = 1'b0;
      if (en) begin
         hs          = !((hc >= HS0) && (hc < HS1));
         vs          = !((vc >= VS0) && (vc < VS1));
         active      = (hc < HA) && (vc < VA);
         frame_start = rst_n && (hc == '0) && (vc == '0);
         frame_last  = (hc == HLAST) && (vc == VLAST);
      end
   end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout top: shadowed origin/scale, image window, framebuffer addressing, output alignment.
// Define VGA_DBUF_EN for front/back buffer swapping at the start of vertical blanking.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int      H_ACTIVE   = DEF_H_ACTIVE,
   parameter int      H_FP       = DEF_H_FP,
   parameter int      H_SYNC     = DEF_H_SYNC,
   parameter int      H_BP       = DEF_H_BP,
   parameter int      V_ACTIVE   = DEF_V_ACTIVE,
   parameter int      V_FP       = DEF_V_FP,
   parameter int      V_SYNC     = DEF_V_SYNC,
   parameter int      V_BP       = DEF_V_BP,
   parameter int      IMG_W      = 256,
   parameter int      IMG_H      = 256,
   parameter int      MEM_LAT    = 1,
   parameter rgb444_t BORDER_RGB = 12'h000,
`ifdef VGA_DBUF_EN
   localparam int     RAW        = $clog2(IMG_W * IMG_H) + 1
`else
   localparam int     RAW        = $clog2(IMG_W * IMG_H)
`endif
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic [9:0]     x0,
   input  logic [8:0]     y0,
   input  logic           scale2,
   input  logic           swap_req,
   output logic           swap_ack,
   output logic           front_sel,
   output logic [RAW-1:0] fb_raddr,
   input  logic [11:0]    fb_rdata,
   output logic           frame_start,
   output logic           VGA_HS,
   output logic           VGA_VS,
   output logic           VGA_BLANK_N,
   output logic           VGA_SYNC_N,
   output logic [7:0]     VGA_R,
   output logic [7:0]     VGA_G,
   output logic [7:0]     VGA_B
);

   localparam int CW = $clog2(IMG_W);
   localparam int AW = $clog2(IMG_W * IMG_H);
   localparam int RW = AW - CW;

   logic [CNT_W-1:0] hc, vc;
   logic             hs, vs, active, frame_last;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .hc          (hc),
      .vc          (vc),
      .hs          (hs),
      .vs          (vs),
      .active      (active),
      .frame_start (frame_start),
      .frame_last  (frame_last)
   );

   logic       en_q, first;
   logic [9:0] sx0, ex0;
   logic [8:0] sy0, ey0;
   logic       ss2, es2;

   // The first cycle after en rises uses the live inputs so the restarted frame is consistent.
   assign first = en && !en_q;
   assign ex0   = first ? x0 : sx0;
   assign ey0   = first ? y0 : sy0;
   assign es2   = first ? scale2 : ss2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q <= 1'b0;
         sx0  <= '0;
         sy0  <= '0;
         ss2  <= 1'b0;
      end else begin
         en_q <= en;
         if (first || frame_last) begin
            sx0 <= x0;
            sy0 <= y0;
            ss2 <= scale2;
         end
      end
   end

   logic [CNT_W-1:0] x_lo, y_lo, w_span, h_span, dx, dy, xs, ys;
   logic             in_img;
   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [RAW-1:0]   addr;
   logic             unused_bits;

   assign x_lo   = {1'b0, ex0};
   assign y_lo   = {2'b00, ey0};
   assign w_span = es2 ? CNT_W'(2 * IMG_W) : CNT_W'(IMG_W);
   assign h_span = es2 ? CNT_W'(2 * IMG_H) : CNT_W'(IMG_H);
   assign in_img = active && (hc >= x_lo) && (hc < x_lo + w_span)
                          && (vc >= y_lo) && (vc < y_lo + h_span);
   assign dx     = hc - x_lo;
   assign dy     = vc - y_lo;
   assign xs     = dx >> es2;
   assign ys     = dy >> es2;
   assign col    = xs[CW-1:0];
   assign row    = ys[RW-1:0];
   assign unused_bits = ^{xs[CNT_W-1:CW], ys[CNT_W-1:RW]};

`ifdef VGA_DBUF_EN
   logic pending, swap_pt;

   assign addr    = {front_sel, row, col};
   assign swap_pt = en && (hc == '0) && (vc == CNT_W'(V_ACTIVE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= 1'b0;
         front_sel <= 1'b0;
         swap_ack  <= 1'b0;
      end else begin
         swap_ack <= 1'b0;
         if (swap_pt && (pending || swap_req)) begin
            front_sel <= !front_sel;
            swap_ack  <= 1'b1;
            pending   <= 1'b0;
         end else if (swap_req) begin
            pending <= 1'b1;
         end
      end
   end
`else
   logic unused_swap;

   assign addr        = {row, col};
   assign front_sel   = 1'b0;
   assign swap_ack    = 1'b0;
   assign unused_swap = swap_req;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fb_raddr <= '0;
      else if (in_img)
         fb_raddr <= addr;
   end

   // Control bits travel alongside the memory read so colour and sync leave together.
   ctl_t [MEM_LAT:0] pipe;
   ctl_t             cur, tail;

   assign cur  = '{hs: hs, vs: vs, active: active, inwin: in_img};
   assign tail = pipe[MEM_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pipe <= {(MEM_LAT + 1){CTL_IDLE}};
      else if (!en)
         pipe <= {(MEM_LAT + 1){CTL_IDLE}};
      else
         pipe <= {pipe[MEM_LAT-1:0], cur};
   end

   logic    nxt_hs, nxt_vs, nxt_blank_n;
   rgb444_t pix;

   always_comb begin
      nxt_hs      = 1'b1;
      nxt_vs      = 1'b1;
      nxt_blank_n = 1'b0;
      pix         = '0;
      if (en) begin
         nxt_hs      = tail.hs;
         nxt_vs      = tail.vs;
         nxt_blank_n = tail.active;
         if (tail.inwin)
            pix = fb_rdata;
         else if (tail.active)
            pix = BORDER_RGB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else begin
         VGA_HS      <= nxt_hs;
         VGA_VS      <= nxt_vs;
         VGA_BLANK_N <= nxt_blank_n;
         VGA_R       <= expand4to8(pix.r);
         VGA_G       <= expand4to8(pix.g);
         VGA_B       <= expand4to8(pix.b);
      end
   end

   assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a reduced raster; a cycle model queues expected outputs.
module tb_vga_scanout;
   import vga_pkg::*;

   localparam int HA = 40, HF = 4, HSW = 6, HB = 6;
   localparam int VA = 20, VF = 2, VSW = 2, VB = 3;
   localparam int HT = HA + HF + HSW + HB;
   localparam int VT = VA + VF + VSW + VB;
   localparam int IW = 16, IH = 8, ML = 2, L = ML + 2;
   localparam int AW = $clog2(IW * IH);
   localparam logic [11:0] BRD = 12'h3C7;
`ifdef VGA_DBUF_EN
   localparam int RAW = AW + 1;
`else
   localparam int RAW = AW;
`endif
   localparam logic [26:0] IDLE = {1'b1, 1'b1, 1'b0, 24'h0};

   logic           clk, rst_n, en, scale2, swap_req, swap_ack, front_sel, frame_start;
   logic [9:0]     x0;
   logic [8:0]     y0;
   logic [RAW-1:0] fb_raddr;
   logic [11:0]    fb_rdata;
   logic           VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
   logic [7:0]     VGA_R, VGA_G, VGA_B;

   vga_scanout #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
      .IMG_W (IW), .IMG_H (IH), .MEM_LAT (ML), .BORDER_RGB (BRD)
   ) dut (
      .clk (clk), .rst_n (rst_n), .en (en), .x0 (x0), .y0 (y0), .scale2 (scale2),
      .swap_req (swap_req), .swap_ack (swap_ack), .front_sel (front_sel),
      .fb_raddr (fb_raddr), .fb_rdata (fb_rdata), .frame_start (frame_start),
      .VGA_HS (VGA_HS), .VGA_VS (VGA_VS), .VGA_BLANK_N (VGA_BLANK_N),
      .VGA_SYNC_N (VGA_SYNC_N), .VGA_R (VGA_R), .VGA_G (VGA_G), .VGA_B (VGA_B)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] fmem(input logic [RAW-1:0] a);
      return 12'((int'(a) * 41) ^ 'h5A3);
   endfunction

   function automatic logic [23:0] widen(input logic [11:0] c);
      return {8'(c[11:8] * 17), 8'(c[7:4] * 17), 8'(c[3:0] * 17)};
   endfunction

   logic [11:0] mem_pipe [ML];
   always @(posedge clk) begin
      for (int i = ML - 1; i > 0; i--) mem_pipe[i] <= mem_pipe[i-1];
      mem_pipe[0] <= fmem(fb_raddr);
   end
   assign fb_rdata = mem_pipe[ML-1];

   int unsigned checks = 0, failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int             mhc, mvc, sx0, sy0, ex0, ey0, s, a;
   bit             ss2, es2, en_prev, pend, mfront, mack, first, act, hs_e, vs_e, inw;
   logic [RAW-1:0] mraddr;
   logic [11:0]    col12;
   logic [26:0]    q[$];
   logic [26:0]    exp_v;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_vga", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, IDLE);
         chk("rst_raddr", fb_raddr, 0);
         chk("rst_frame_start", frame_start, 0);
         chk("rst_swap_ack", swap_ack, 0);
         chk("rst_front_sel", front_sel, 0);
         mhc = 0; mvc = 0; en_prev = 0; pend = 0; mfront = 0; mack = 0; mraddr = '0;
         sx0 = 0; sy0 = 0; ss2 = 0;
         q.delete();
         for (int i = 0; i < L; i++) q.push_back(IDLE);
      end else begin
         first = en && !en_prev;
         ex0   = first ? int'(x0) : sx0;
         ey0   = first ? int'(y0) : sy0;
         es2   = first ? scale2 : ss2;
         s     = es2 ? 2 : 1;
         act   = en && mhc < HA && mvc < VA;
         hs_e  = !(en && mhc >= HA + HF && mhc < HA + HF + HSW);
         vs_e  = !(en && mvc >= VA + VF && mvc < VA + VF + VSW);
         inw   = act && mhc >= ex0 && mhc < ex0 + IW * s && mvc >= ey0 && mvc < ey0 + IH * s;
         a     = ((mvc - ey0) / s) * IW + (mhc - ex0) / s;
`ifdef VGA_DBUF_EN
         if (mfront) a = a + (1 << AW);
`endif
         col12 = inw ? fmem(RAW'(a)) : (act ? BRD : 12'h000);

         chk("frame_start", frame_start, en && mhc == 0 && mvc == 0);
         chk("fb_raddr", fb_raddr, mraddr);
         chk("front_sel", front_sel, mfront);
         chk("swap_ack", swap_ack, mack);
         chk("sync_n", VGA_SYNC_N, 0);
         exp_v = q.pop_front();
         chk("vga_out", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, exp_v);

         if (inw) mraddr = RAW'(a);
         if (!en) begin
            for (int i = 0; i < q.size(); i++) q[i] = IDLE;
            q.push_back(IDLE);
         end else begin
            q.push_back({hs_e, vs_e, act, widen(col12)});
         end
`ifdef VGA_DBUF_EN
         if (en && mhc == 0 && mvc == VA && (pend || swap_req)) begin
            mfront = !mfront; mack = 1; pend = 0;
         end else begin
            mack = 0;
            if (swap_req) pend = 1;
         end
`endif
         if (first || (en && mhc == HT - 1 && mvc == VT - 1)) begin
            sx0 = int'(x0); sy0 = int'(y0); ss2 = scale2;
         end
         en_prev = en;
         if (!en) begin
            mhc = 0; mvc = 0;
         end else if (mhc == HT - 1) begin
            mhc = 0;
            mvc = (mvc == VT - 1) ? 0 : mvc + 1;
         end else begin
            mhc = mhc + 1;
         end
      end
   end

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns just before the cycle whose counter state is (h,v); inputs driven next apply there.
   task automatic wait_state(input int h, input int v);
      bit timed_out;
      timed_out = 1;
      for (int i = 0; i < HT * VT + 10; i++) begin
         @(negedge clk);
         #2;
         if (mhc == h && mvc == v) begin
            timed_out = 0;
            break;
         end
      end
      chk("wait_state_timeout", timed_out, 0);
      @(posedge clk);
      #1;
   endtask

   int n;

   initial begin
      rst_n = 0; en = 0; x0 = '0; y0 = '0; scale2 = 0; swap_req = 0;
      run(3);
      rst_n = 1;
      run(2);
      x0 = 10'd5; y0 = 9'd3;
      en = 1;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (VGA_HS === 1'b0) break;
      end
      chk("hs_first_fall_cycle", n, HA + HF + L);
      run(HT * VT);

      // mid-frame change with clipping on both axes; must wait for the frame boundary
      x0 = 10'd30; y0 = 9'd15; scale2 = 1;
      run(2 * HT * VT);
      x0 = 10'd0; y0 = 9'd0; scale2 = 1;
      run(HT * VT + HT * VT / 2);

      x0 = 10'd12; y0 = 9'd4; scale2 = 0;
      wait_state(0, 2);
      swap_req = 1; run(1); swap_req = 0;
      run(10);
      swap_req = 1; run(1); swap_req = 0;
      run(HT * VT);
      wait_state(0, VA);
      swap_req = 1; run(1); swap_req = 0;
      run(100);

      wait_state(10, 5);
      en = 0; swap_req = 1; x0 = 10'd7; y0 = 9'd2; scale2 = 0;
      run(1);
      swap_req = 0;
      run(4);
      en = 1;
      run(2 * HT * VT);

      wait_state(20, 8);
      rst_n = 0;
      run(2);
      rst_n = 1;
      run(HT * VT + 100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
